// File: rtl/datamem_arbiter_pkg.sv
// Shared definitions for the DATAMEM arbiter: port identifiers, the memory
// depth, the request bundle type and the address range check.
package datamem_arbiter_pkg;

  // Number of words in DATAMEM; valid word addresses are 0..DATAMEM_DEPTH-1.
  localparam int DATAMEM_DEPTH = 32;

  // Identifies which requester owns the memory in a given cycle.
  localparam logic [1:0] PORT_NONE = 2'd0;
  localparam logic [1:0] PORT_CPU  = 2'd1;
  localparam logic [1:0] PORT_DBG  = 2'd2;

  // One access request as presented by either requester.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // True when a word address falls inside the memory.
  function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
    return addr < 32'(depth);
  endfunction

endpackage

// File: rtl/datamem_arbiter_starve_ctr.sv
// Saturating wait counter for the low-priority requester. It counts
// consecutive denied cycles and raises at_limit once the requester has waited
// MAX_WAIT cycles, which the grant logic uses to force one access through.
module arb_starve_ctr #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt;

  // Count denied cycles, holding at LIMIT; a grant or a dropped request clears.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Limit compare drives the starvation override in the grant logic.
  assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port arbiter in front of the single-port DATAMEM. The CPU (MEM stage)
// has fixed priority; the debug/loader port is guaranteed one access after
// MAX_WAIT consecutive denied cycles. Read data is registered back to the
// requester that won, one cycle after its grant.
module datamem_arbiter
  import datamem_arbiter_pkg::*;
#(
  parameter int DEPTH    = DATAMEM_DEPTH,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  // CPU (pipeline MEM stage) port
  input  logic        CpuReq,
  input  logic        CpuWe,
  input  logic [31:0] CpuAddr,
  input  logic [31:0] CpuWData,
  output logic        CpuStall,
  output logic [31:0] CpuRData,
  output logic        CpuValid,
  // Debug / loader port
  input  logic        DbgReq,
  input  logic        DbgWe,
  input  logic [31:0] DbgAddr,
  input  logic [31:0] DbgWData,
  output logic        DbgGnt,
  output logic [31:0] DbgRData,
  output logic        DbgValid,
  // Error pulse for an out-of-range granted access
  output logic        AddrErr,
  // DATAMEM interface
  output logic        MemWrite,
  output logic        MemRead,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] Data
);

  mem_req_t   cpu_req;
  mem_req_t   dbg_req;
  mem_req_t   win_req;
  logic [1:0] win_port;
  logic       starve_limit;
  logic       dbg_win;
  logic       cpu_win;
  logic       win_valid;
  logic       in_range;
  logic [31:0] rd_word;
  logic       cpu_rd_done;
  logic       dbg_rd_done;

  assign cpu_req = '{we: CpuWe, addr: CpuAddr, wdata: CpuWData};
  assign dbg_req = '{we: DbgWe, addr: DbgAddr, wdata: DbgWData};

  // Wait counter: counts only while DBG asks and loses; clears otherwise.
  arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .inc      (DbgReq & ~dbg_win),
    .clr      (~DbgReq | dbg_win),
    .at_limit (starve_limit)
  );

  // Grant decision: CPU wins by default, DBG wins when CPU is idle or DBG has
  // waited long enough. Reset holds both sides idle.
  // NOTE: every signal assigned in an always_comb gets a default on entry so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    dbg_win  = 1'b0;
    cpu_win  = 1'b0;
    win_port = PORT_NONE;
    if (!rst) begin
      dbg_win = DbgReq & (~CpuReq | starve_limit);
      cpu_win = CpuReq & ~dbg_win;
    end
    if (dbg_win) begin
      win_port = PORT_DBG;
    end else if (cpu_win) begin
      win_port = PORT_CPU;
    end
  end

  assign DbgGnt   = dbg_win;
  assign CpuStall = CpuReq & ~cpu_win;

  // Select the winning request; with no winner the memory bus is all zeros.
  always_comb begin
    win_req = '0;
    case (win_port)
      PORT_CPU: win_req = cpu_req;
      PORT_DBG: win_req = dbg_req;
      default:  win_req = '0;
    endcase
  end

  assign win_valid = (win_port != PORT_NONE);
  assign in_range  = addr_in_range(win_req.addr, DEPTH);

  // Memory drive: an out-of-range winner keeps its address on the bus but
  // neither reads nor writes, so DATAMEM is never touched outside its range.
  assign Address   = win_req.addr;
  assign WriteData = win_req.wdata;
  assign MemWrite  = win_valid & win_req.we & in_range;
  assign MemRead   = win_valid & ~win_req.we & in_range;

  // An out-of-range read still completes, returning zero instead of Data.
  assign rd_word     = in_range ? Data : '0;
  assign cpu_rd_done = (win_port == PORT_CPU) & ~win_req.we;
  assign dbg_rd_done = (win_port == PORT_DBG) & ~win_req.we;

  // Response registers: capture read data at the end of the grant cycle and
  // pulse Valid for one cycle; the losing side keeps its last read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      CpuRData <= '0;
      DbgRData <= '0;
      CpuValid <= 1'b0;
      DbgValid <= 1'b0;
      AddrErr  <= 1'b0;
    end else begin
      CpuValid <= cpu_rd_done;
      DbgValid <= dbg_rd_done;
      AddrErr  <= win_valid & ~in_range;
      if (cpu_rd_done) begin
        CpuRData <= rd_word;
      end
      if (dbg_rd_done) begin
        DbgRData <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Randomised scoreboard bench for datamem_arbiter. A directed prologue walks
// the key scenarios, then random traffic follows. Each cycle the reference
// model queues the expected bus/grant outputs and the expected registered
// responses; an independent monitor pops and compares them on the falling edge.
module tb_datamem_arbiter;
  import datamem_arbiter_pkg::*;

  localparam int DEPTH    = 32;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        CpuReq, CpuWe, CpuStall, CpuValid;
  logic [31:0] CpuAddr, CpuWData, CpuRData;
  logic        DbgReq, DbgWe, DbgGnt, DbgValid;
  logic [31:0] DbgAddr, DbgWData, DbgRData;
  logic        AddrErr, MemWrite, MemRead;
  logic [31:0] Address, WriteData, Data;

  datamem_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuStall(CpuStall), .CpuRData(CpuRData), .CpuValid(CpuValid),
    .DbgReq(DbgReq), .DbgWe(DbgWe), .DbgAddr(DbgAddr), .DbgWData(DbgWData),
    .DbgGnt(DbgGnt), .DbgRData(DbgRData), .DbgValid(DbgValid),
    .AddrErr(AddrErr), .MemWrite(MemWrite), .MemRead(MemRead),
    .Address(Address), .WriteData(WriteData), .Data(Data)
  );

  always #5 clk = ~clk;

  // DATAMEM itself: synchronous write, combinational read.
  logic [31:0] dm [0:DEPTH-1];
  assign Data = dm[Address[4:0]];
  always @(posedge clk) if (MemWrite) dm[Address[4:0]] <= WriteData;

  function automatic logic [31:0] init_word(input int i);
    return (i == 1) ? 32'd1 : 32'(i * 5 + 1);   // word 2 holds 11
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int          due;
    logic        stall, gnt, mw, mr;
    logic [31:0] addr, wd;
  } comb_exp_t;

  typedef struct {
    int          due;
    logic        cv, dv, err;
    logic [31:0] crd, drd;
  } reg_exp_t;

  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares whatever expectations fall due in the current cycle.
  always @(negedge clk) begin
    if (comb_q.size() > 0 && comb_q[0].due == cyc) begin
      comb_exp_t c;
      c = comb_q.pop_front();
      check("CpuStall",  {31'd0, CpuStall}, {31'd0, c.stall});
      check("DbgGnt",    {31'd0, DbgGnt},   {31'd0, c.gnt});
      check("MemWrite",  {31'd0, MemWrite}, {31'd0, c.mw});
      check("MemRead",   {31'd0, MemRead},  {31'd0, c.mr});
      check("Address",   Address,   c.addr);
      check("WriteData", WriteData, c.wd);
    end
    if (reg_q.size() > 0 && reg_q[0].due == cyc) begin
      reg_exp_t r;
      r = reg_q.pop_front();
      check("CpuValid", {31'd0, CpuValid}, {31'd0, r.cv});
      check("DbgValid", {31'd0, DbgValid}, {31'd0, r.dv});
      check("AddrErr",  {31'd0, AddrErr},  {31'd0, r.err});
      check("CpuRData", CpuRData, r.crd);
      check("DbgRData", DbgRData, r.drd);
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:DEPTH-1];
  int          denied;        // consecutive cycles DBG asked and lost
  logic [31:0] held_cpu_rd, held_dbg_rd;
  logic        last_stall, last_gnt;

  // Applies one cycle of stimulus and records what the DUT must do.
  task automatic drive(input logic r,
                       input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                       input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd);
    comb_exp_t   c;
    reg_exp_t    q;
    logic        dw, cw, we, ok;
    logic [31:0] a, w, val;
    @(posedge clk);
    #1;
    rst = r;
    CpuReq = creq; CpuWe = cwe; CpuAddr = caddr; CpuWData = cwd;
    DbgReq = dreq; DbgWe = dwe; DbgAddr = daddr; DbgWData = dwd;

    c = '{due: cyc, stall: 1'b0, gnt: 1'b0, mw: 1'b0, mr: 1'b0, addr: 32'd0, wd: 32'd0};
    q = '{due: cyc + 1, cv: 1'b0, dv: 1'b0, err: 1'b0, crd: 32'd0, drd: 32'd0};
    if (r) begin
      c.stall = creq;
      denied = 0;
      held_cpu_rd = 32'd0;
      held_dbg_rd = 32'd0;
    end else begin
      dw = dreq && (!creq || denied >= MAX_WAIT);
      cw = creq && !dw;
      c.gnt = dw;
      c.stall = creq && !cw;
      if (dw || cw) begin
        a  = dw ? daddr : caddr;
        w  = dw ? dwd : cwd;
        we = dw ? dwe : cwe;
        ok = a < 32'(DEPTH);
        c.addr = a;
        c.wd   = w;
        c.mw   = we && ok;
        c.mr   = !we && ok;
        val = ok ? ref_mem[a[4:0]] : 32'd0;
        if (we && ok) ref_mem[a[4:0]] = w;
        q.err = !ok;
        if (!we && cw) begin q.cv = 1'b1; held_cpu_rd = val; end
        if (!we && dw) begin q.dv = 1'b1; held_dbg_rd = val; end
      end
      if (dreq && !dw) denied = (denied + 1 > MAX_WAIT) ? MAX_WAIT : denied + 1;
      else             denied = 0;
    end
    q.crd = held_cpu_rd;
    q.drd = held_dbg_rd;
    last_stall = c.stall;
    last_gnt   = c.gnt;
    comb_q.push_back(c);
    reg_q.push_back(q);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    return ($urandom_range(0, 9) == 0) ? 32'($urandom_range(32, 100)) : 32'($urandom_range(0, 31));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic        creq, cwe, dreq, dwe;
    logic [31:0] caddr, cwd, daddr, dwd;

    rst = 1'b1;
    CpuReq = 1'b0; CpuWe = 1'b0; CpuAddr = '0; CpuWData = '0;
    DbgReq = 1'b0; DbgWe = 1'b0; DbgAddr = '0; DbgWData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dm[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    denied = 0;
    held_cpu_rd = '0;
    held_dbg_rd = '0;

    // Reset with a pending CPU read, then the read of word 2 goes through.
    drive(1'b1, 1'b1, 1'b0, 32'd2, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'd2, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'd2, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle();

    // CPU write then read-back of word 5.
    drive(1'b0, 1'b1, 1'b1, 32'd5, 32'hA5A5A5A5, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'd5, 32'd0,        1'b0, 1'b0, 32'd0, 32'd0);
    idle();

    // Contention: CPU busy every cycle, DBG read of word 1 wins on the 5th.
    for (int i = 0; i < MAX_WAIT + 1; i++)
      drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd1, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle();

    // DBG alone writes word 31; CPU later reads it back.
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd31, 32'd7);
    idle();
    drive(1'b0, 1'b1, 1'b0, 32'd31, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle();

    // Out-of-range CPU read.
    drive(1'b0, 1'b1, 1'b0, 32'd40, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle();

    // Reset right after a granted read.
    drive(1'b0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    idle();
    idle();

    // Random traffic; an unserved request is normally held, sometimes dropped.
    creq = 1'b0; cwe = 1'b0; caddr = '0; cwd = '0;
    dreq = 1'b0; dwe = 1'b0; daddr = '0; dwd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!(creq && last_stall && $urandom_range(0, 9) != 0)) begin
        creq  = $urandom_range(0, 9) < 6;
        cwe   = $urandom_range(0, 2) == 0;
        caddr = rand_addr();
        cwd   = $urandom;
      end
      if (!(dreq && !last_gnt && $urandom_range(0, 9) != 0)) begin
        dreq  = $urandom_range(0, 9) < 5;
        dwe   = $urandom_range(0, 1) == 0;
        daddr = rand_addr();
        dwd   = $urandom;
      end
      drive($urandom_range(0, 79) == 0, creq, cwe, caddr, cwd, dreq, dwe, daddr, dwd);
    end
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(comb_q.size() + reg_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Arbitrates single-port data memory DATAMEM between two requesters: pipeline MEM stage (CPU port) and debug/loader port (DBG port).
- DATAMEM has a synchronous write and a combinational read. The arbiter drives DATAMEM's MemWrite, MemRead, Address and WriteData, and registers the read data back to the winning requester.
- CPU port has fixed priority. A wait counter guarantees DBG service within MAX_WAIT cycles. CPU is stalled when it loses.

Parameters:
- DEPTH, 32, number of words in DATAMEM; valid word addresses are 0..DEPTH-1.
- MAX_WAIT, 4, consecutive cycles DBG may be denied before it wins one access; legal range 1..15.
- CNT_W, 4, width of the DBG wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- CpuReq  in  1  CPU access request for this cycle.
- CpuWe  in  1  1 = write, 0 = read; meaningful only while CpuReq=1.
- CpuAddr  in  32  CPU word address.
- CpuWData  in  32  CPU write data.
- CpuStall  out  1  CPU request not served this cycle; pipeline holds the request.
- CpuRData  out  32  registered CPU read data.
- CpuValid  out  1  CpuRData valid; one-cycle pulse.
- DbgReq  in  1  DBG access request.
- DbgWe  in  1  DBG write enable.
- DbgAddr  in  32  DBG word address.
- DbgWData  in  32  DBG write data.
- DbgGnt  out  1  DBG request served this cycle.
- DbgRData  out  32  registered DBG read data.
- DbgValid  out  1  DbgRData valid; one-cycle pulse.
- AddrErr  out  1  registered pulse: the granted access had address >= DEPTH.
- MemWrite  out  1  to DATAMEM.
- MemRead  out  1  to DATAMEM.
- Address  out  32  to DATAMEM.
- WriteData  out  32  to DATAMEM.
- Data  in  32  from DATAMEM; combinational read data.

Behaviour:
- Reset (rst=1 at a rising edge):
  - CpuRData=0, DbgRData=0, CpuValid=0, DbgValid=0, AddrErr=0; wait counter=0.
  - While rst=1, the grant logic is forced idle: MemWrite=0, MemRead=0, DbgGnt=0, CpuStall=CpuReq.
- Grant decision (combinational, every cycle):
  - dbg_win = DbgReq & (~CpuReq | wait_cnt == MAX_WAIT).
  - cpu_win = CpuReq & ~dbg_win.
  - At most one winner per cycle.
- Outputs derived from the grant:
  - DbgGnt = dbg_win.
  - CpuStall = CpuReq & ~cpu_win.
- Memory drive for the winner:
  - Address = winner address; WriteData = winner write data.
  - MemWrite = winner We; MemRead = ~winner We.
  - With no winner: MemWrite=0, MemRead=0, Address=0, WriteData=0.
- Address check: if the winner address >= DEPTH, force MemWrite=0 and MemRead=0 and set AddrErr=1 on the next cycle. The grant still counts as served: the stall is released and Valid still pulses for a read, with RData=0.
- Read latency:
  - Data is captured at the rising edge that ends the grant cycle.
  - The winner's Valid=1 and RData=Data during the following cycle only.
  - The non-winner's RData holds its value.
- Write latency: DATAMEM updates at the edge that ends the grant cycle. No Valid pulse for writes.
- Wait counter:
  - Increments (saturating at MAX_WAIT) when DbgReq & ~dbg_win.
  - Clears to 0 when dbg_win or DbgReq=0.
- Handshake:
  - A requester holds Req, We, Addr and WData stable until served (CPU: CpuStall=0; DBG: DbgGnt=1).
  - Dropping Req before service is legal; the wait counter then clears.
- Read-after-write, same address, back-to-back grants: the read returns the new data, since the write commits before the read cycle.
- rst asserted mid-operation: any in-flight Valid is cancelled (Valid=0 next cycle); writes in the reset cycle are suppressed.

Decomposition:
- Shared package: port-ID constants (PORT_NONE, PORT_CPU, PORT_DBG) and the DATAMEM DEPTH constant.
- One sub-module, arb_starve_ctr: saturating wait counter with clear/increment/limit-compare output.
- Grant mux and response registers stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with CpuReq=1 → MemRead=0, CpuStall=1, all Valid=0, RData=0. After reset release, CpuReq read of address 2 → CpuValid=1 next cycle with CpuRData=11.
- Single CPU write: CpuReq, CpuWe, CpuAddr=5, CpuWData=0xA5A5A5A5, then a CPU read of address 5 the next cycle → CpuStall=0 both cycles; CpuRData=0xA5A5A5A5 one cycle after the read.
- Contention: CpuReq held continuously and DbgReq read of address 1 held with MAX_WAIT=4 → DbgGnt=0 for 4 cycles, then DbgGnt=1 and CpuStall=1 in the 5th cycle. DbgValid=1 with DbgRData=1 on the following cycle; the counter is back at 0.
- DBG alone: DbgReq write of address 31 with data 7, CpuReq=0 → DbgGnt=1 immediately and MemWrite=1; a later CPU read of address 31 returns 7.
- Out of range: CpuReq read of address 40 → MemRead=0, CpuStall=0; next cycle AddrErr=1, CpuValid=1, CpuRData=0.
- Reset mid-read: CPU read granted, rst=1 in the following cycle → CpuValid=0 and CpuRData=0 after that edge.
